// File: rtl/fir_stream_filter_if.sv
// Valid/ready sample stream carrying one signed word per transfer.
interface fir_stream_filter_if #(
  parameter int unsigned W = 16
) ();
  logic                valid;
  logic                ready;
  logic signed [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_stream_filter.sv
// Runtime-programmable FIR filter, one tap per clock on a single MAC, valid/ready on both sides.
// Define ROUND_SAT_EN for round-half-up plus saturation on the output; default truncates and wraps.
module fir_stream_filter #(
  parameter int unsigned NTAPS  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  fir_stream_filter_if.slave         in_st,
  fir_stream_filter_if.master        out_st,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_err
);

  localparam int unsigned TW    = $clog2(NTAPS);
  localparam int unsigned PW    = DATA_W + COEF_W;
  localparam int unsigned ACC_W = DATA_W + COEF_W + $clog2(NTAPS);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [COEF_W-1:0] c_q [NTAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_next;
  logic [TW-1:0]            tap_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     coef_err_q;

  logic signed [PW-1:0]     prod;
  logic signed [OUT_W-1:0]  scaled;
  logic                     in_ready;
  logic                     fire;
  logic                     last_tap;
  logic                     coef_ok;

  // in_ready_q is low for the first cycle after reset and while busy
  assign in_ready     = in_ready_q & enable & ~rst;
  assign in_st.ready  = in_ready;
  assign out_st.valid = out_valid_q;
  assign out_st.data  = out_data_q;
  assign coef_err     = coef_err_q;

  assign fire     = in_st.valid & in_ready & (state_q == StIdle);
  assign last_tap = (tap_q == TW'(NTAPS - 1));
  assign coef_ok  = (state_q == StIdle) && (32'(coef_addr) < NTAPS);

  assign prod     = PW'(x_q[tap_q]) * PW'(c_q[tap_q]);
  assign acc_next = acc_q + ACC_W'(prod);

`ifdef ROUND_SAT_EN
  localparam logic [ACC_W:0] RoundK = (SHIFT == 0) ? '0 : ((ACC_W + 1)'(1) << (SHIFT - 1));
  logic signed [ACC_W:0] rnd;

  always_comb begin
    rnd = ((ACC_W + 1)'(acc_next) + $signed(RoundK)) >>> SHIFT;
    // In range when every bit above the output sign bit matches it
    if (rnd[ACC_W:OUT_W-1] == {(ACC_W - OUT_W + 2){rnd[ACC_W]}}) begin
      scaled = rnd[OUT_W-1:0];
    end else if (rnd[ACC_W]) begin
      scaled = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      scaled = {1'b0, {(OUT_W - 1){1'b1}}};
    end
  end
`else
  assign scaled = OUT_W'(acc_next >>> SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q       <= '0;
      tap_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
    end else begin
      coef_err_q <= coef_we & ~coef_ok;
      // Lands at the same edge as a handshake, so that sample's MAC sees it
      if (coef_we && coef_ok) begin
        c_q[coef_addr] <= coef_data;
      end
      if (enable) begin
        case (state_q)
          StIdle: begin
            if (fire) begin
              x_q[0] <= in_st.data;
              for (int i = 1; i < NTAPS; i++) begin
                x_q[i] <= x_q[i-1];
              end
              acc_q      <= '0;
              tap_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StMac;
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          StMac: begin
            acc_q <= acc_next;
            if (last_tap) begin
              tap_q       <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= scaled;
              state_q     <= StOut;
            end else begin
              tap_q <= tap_q + 1'b1;
            end
          end
          StOut: begin
            if (out_st.ready) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q == StIdle) begin
        in_ready_q <= 1'b1;
      end
    end
  end

endmodule
